// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate extender: S1 captures Ctrl/Imm26, S2 holds the extended result.
// Define IMMGEN_ERR_EN to add the OutErr flag and the saturating ErrCnt illegal-code counter.
module imm_gen_pipe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              InValid,
  output logic              InReady,
  input  logic [25:0]       Imm26,
  input  logic [2:0]        Ctrl,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] BusOut
`ifdef IMMGEN_ERR_EN
  ,
  output logic              OutErr,
  output logic [CNT_W-1:0]  ErrCnt
`endif
);

  localparam logic [2:0] CtrlI   = 3'b000;
  localparam logic [2:0] CtrlD   = 3'b001;
  localparam logic [2:0] CtrlB   = 3'b010;
  localparam logic [2:0] CtrlCb  = 3'b011;
  localparam logic [2:0] CtrlIw  = 3'b100;
  localparam logic [2:0] CtrlIsh = 3'b101;

  function automatic logic is_illegal(input logic [2:0] ctrl, input logic [25:0] imm);
    logic ill;
    ill = 1'b0;
    case (ctrl)
      CtrlI, CtrlD, CtrlB, CtrlCb, CtrlIsh: ill = 1'b0;
      // A 32-bit result cannot hold a halfword shifted by 32 or 48.
      CtrlIw:  ill = (DATA_W == 32) && imm[22];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] ctrl, input logic [25:0] imm);
    logic [63:0] r;
    r = '0;
    case (ctrl)
      CtrlI:   r = {52'b0, imm[21:10]};
      CtrlD:   r = {{55{imm[20]}}, imm[20:12]};
      CtrlB:   r = {{38{imm[25]}}, imm};
      CtrlCb:  r = {{45{imm[23]}}, imm[23:5]};
      CtrlIw:  r = {48'b0, imm[20:5]} << {imm[22:21], 4'b0};
      CtrlIsh: r = imm[22] ? {40'b0, imm[21:10], 12'b0} : {52'b0, imm[21:10]};
      default: r = '0;
    endcase
    return DATA_W'(r);
  endfunction

  logic              in_xfer;
  logic              s1_to_s2;
  logic              s1_valid_q;
  logic [2:0]        s1_ctrl_q;
  logic [25:0]       s1_imm_q;
  logic              s1_illegal;
  logic [DATA_W-1:0] s1_ext;
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;

  assign InReady  = !(s1_valid_q && s2_valid_q && !OutReady);
  assign in_xfer  = InValid && InReady;
  assign s1_to_s2 = s1_valid_q && (!s2_valid_q || OutReady);
  assign OutValid = s2_valid_q;
  assign BusOut   = s2_data_q;

  always_comb begin
    s1_illegal = is_illegal(s1_ctrl_q, s1_imm_q);
    s1_ext     = s1_illegal ? '0 : extend(s1_ctrl_q, s1_imm_q);
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_imm_q   <= '0;
    end else if (in_xfer) begin
      s1_valid_q <= 1'b1;
      s1_ctrl_q  <= Ctrl;
      s1_imm_q   <= Imm26;
    end else if (s1_to_s2) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (s1_to_s2) begin
      s2_valid_q <= 1'b1;
      s2_data_q  <= s1_ext;
    end else if (OutReady) begin
      s2_valid_q <= 1'b0;
    end
  end

`ifdef IMMGEN_ERR_EN
  logic             s2_err_q;
  logic [CNT_W-1:0] err_cnt_q;

  assign OutErr = s2_err_q;
  assign ErrCnt = err_cnt_q;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      s2_err_q <= 1'b0;
    end else if (s1_to_s2) begin
      s2_err_q <= s1_illegal;
    end
  end

  // Counted at input acceptance, not at output, so stalls never delay the count.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      err_cnt_q <= '0;
    end else if (in_xfer && is_illegal(Ctrl, Imm26) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 64-bit instance driven through a queue-based checker,
// plus a 32-bit instance (CNT_W=2) for the narrow-width and error-counter cases.
module tb_imm_gen_pipe;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        InValid, InReady, OutValid, OutReady;
  logic [25:0] Imm26;
  logic [2:0]  Ctrl;
  logic [63:0] BusOut;

  logic        v32, rdy32, ov32;
  logic [25:0] imm32;
  logic [2:0]  ctrl32;
  logic [31:0] bus32;
`ifdef IMMGEN_ERR_EN
  logic        OutErr, oerr32;
  logic [7:0]  ErrCnt;
  logic [1:0]  cnt32;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [64:0] exp_q[$];
  logic [63:0] held;
  logic        held_v;

  always #5 CLK = ~CLK;

  imm_gen_pipe #(.DATA_W(64), .CNT_W(8)) dut (
    .CLK(CLK), .resetl(resetl), .InValid(InValid), .InReady(InReady), .Imm26(Imm26),
    .Ctrl(Ctrl), .OutValid(OutValid), .OutReady(OutReady), .BusOut(BusOut)
`ifdef IMMGEN_ERR_EN
    , .OutErr(OutErr), .ErrCnt(ErrCnt)
`endif
  );

  imm_gen_pipe #(.DATA_W(32), .CNT_W(2)) dut32 (
    .CLK(CLK), .resetl(resetl), .InValid(v32), .InReady(rdy32), .Imm26(imm32),
    .Ctrl(ctrl32), .OutValid(ov32), .OutReady(1'b1), .BusOut(bus32)
`ifdef IMMGEN_ERR_EN
    , .OutErr(oerr32), .ErrCnt(cnt32)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: sign extension by arithmetic right shift of a left-justified field.
  function automatic logic [64:0] model(input logic [2:0] c, input logic [25:0] i);
    logic signed [63:0] t;
    logic [63:0]        r;
    logic               err;
    t = '0;
    r = '0;
    err = 1'b0;
    case (c)
      3'd0: r = 64'(i[21:10]);
      3'd1: begin t = {i[20:12], 55'b0}; r = t >>> 55; end
      3'd2: begin t = {i, 38'b0};        r = t >>> 38; end
      3'd3: begin t = {i[23:5], 45'b0};  r = t >>> 45; end
      3'd4: r = 64'(i[20:5]) << (32'(i[22:21]) * 16);
      3'd5: r = i[22] ? 64'(i[21:10]) * 64'd4096 : 64'(i[21:10]);
      default: err = 1'b1;
    endcase
    return {err, r};
  endfunction

  task automatic send(input logic [2:0] c, input logic [25:0] i, input logic [63:0] e,
                      input logic ee);
    bit done = 1'b0;
    InValid = 1'b1;
    Ctrl    = c;
    Imm26   = i;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge CLK);
      if (InReady) begin
        exp_q.push_back({ee, e});
        n_acc++;
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    InValid = 1'b0;
    if (!done) check_val("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send32(input logic [2:0] c, input logic [25:0] i);
    v32    = 1'b1;
    ctrl32 = c;
    imm32  = i;
    @(posedge CLK);
    #1;
    v32 = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    logic [64:0] e;
    if (resetl) begin
      if (OutValid && !OutReady) begin
        if (held_v) check_val("stall_hold", BusOut, held);
        held   <= BusOut;
        held_v <= 1'b1;
      end else begin
        held_v <= 1'b0;
      end
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("bus", BusOut, e[63:0]);
`ifdef IMMGEN_ERR_EN
          check_val("out_err", 64'(OutErr), 64'(e[64]));
`endif
        end
      end
    end else begin
      held_v <= 1'b0;
    end
  end

  initial begin
    logic [64:0] m;
    logic [2:0]  c;
    logic [25:0] i;
    int          base;
    held_v   = 1'b0;
    resetl   = 1'b0;
    InValid  = 1'b0;
    Ctrl     = '0;
    Imm26    = '0;
    OutReady = 1'b1;
    v32      = 1'b0;
    ctrl32   = '0;
    imm32    = '0;
    #2;
    check_val("rst_inready", 64'(InReady), 64'd1);
    check_val("rst_outvalid", 64'(OutValid), 64'd0);
    check_val("rst_bus", BusOut, 64'd0);
`ifdef IMMGEN_ERR_EN
    check_val("rst_errcnt", 64'(ErrCnt), 64'd0);
`endif
    @(posedge CLK);
    #1 resetl = 1'b1;
    @(posedge CLK);
    #1;

    // D format, all-ones field, two edges from acceptance to OutValid
    send(3'b001, 26'h01FF000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check_val("d_lat_early", 64'(OutValid), 64'd0);
    @(posedge CLK);
    #1;
    check_val("d_lat_valid", 64'(OutValid), 64'd1);
    check_val("d_lat_bus", BusOut, 64'hFFFF_FFFF_FFFF_FFFF);

    send(3'b100, 26'h077DDE0, 64'hBEEF_0000_0000_0000, 1'b0);
    send(3'b101, 26'h0400400, 64'h0000_0000_0000_1000, 1'b0);
    send(3'b101, 26'h0000400, 64'h0000_0000_0000_0001, 1'b0);
    send(3'b010, 26'h2000000, 64'hFFFF_FFFF_FE00_0000, 1'b0);
    send(3'b011, 26'h0800000, 64'hFFFF_FFFF_FFFC_0000, 1'b0);
    send(3'b000, 26'h3FFFFFF, 64'h0000_0000_0000_0FFF, 1'b0);
    send(3'b110, 26'h3FFFFFF, 64'h0, 1'b1);

    // Random stream against random output back-pressure
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          c = 3'($urandom_range(0, 7));
          i = 26'($urandom);
          m = model(c, i);
          send(c, i, m[63:0], m[64]);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge CLK);
          #1 OutReady = 1'($urandom_range(0, 1));
        end
        OutReady = 1'b1;
      end
    join
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge CLK);
    #1;
    check_val("rand_drain", 64'(exp_q.size()), 64'd0);

    // Four back-to-back inputs with a three-cycle output stall mid-stream
    base = n_acc;
    fork
      begin
        @(negedge CLK);
        @(posedge CLK);
        #1 OutReady = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_val("stall_inready", 64'(InReady), 64'd0);
        check_val("stall_accepted", 64'(n_acc - base), 64'd2);
        @(negedge CLK);
        @(posedge CLK);
        #1 OutReady = 1'b1;
      end
      begin
        for (int k = 1; k <= 4; k++) send(3'b000, 26'(k << 10), 64'(k), 1'b0);
      end
    join
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge CLK);
    #1;
    check_val("stall_drain", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full
    OutReady = 1'b0;
    send(3'b000, 26'h0000400, 64'd1, 1'b0);
    send(3'b000, 26'h0000800, 64'd2, 1'b0);
    check_val("full_s2", 64'(OutValid), 64'd1);
    check_val("full_inready", 64'(InReady), 64'd0);
    #2 resetl = 1'b0;
    #1;
    check_val("midrst_outvalid", 64'(OutValid), 64'd0);
    check_val("midrst_inready", 64'(InReady), 64'd1);
    check_val("midrst_bus", BusOut, 64'd0);
    exp_q.delete();
    @(posedge CLK);
    #1 resetl = 1'b1;
    OutReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_val("post_rst_idle", 64'(OutValid), 64'd0);
    end
    @(posedge CLK);
    #1;
    send(3'b000, 26'h0001400, 64'd5, 1'b0);

    // 32-bit instance
`ifdef IMMGEN_ERR_EN
    check_val("e32_cnt0", 64'(cnt32), 64'd0);
`endif
    for (int k = 0; k < 5; k++) begin
      send32(3'b111, 26'(k * 1237));
      check_val("e32_valid", 64'(ov32), 64'd1);
      check_val("e32_bus", 64'(bus32), 64'd0);
`ifdef IMMGEN_ERR_EN
      check_val("e32_err", 64'(oerr32), 64'd1);
      if (k == 0) check_val("e32_cnt1", 64'(cnt32), 64'd1);
`endif
    end
`ifdef IMMGEN_ERR_EN
    check_val("e32_cnt_sat", 64'(cnt32), 64'd3);
`endif
    send32(3'b100, 26'h077DDE0);
    check_val("iw32_bus", 64'(bus32), 64'd0);
`ifdef IMMGEN_ERR_EN
    check_val("iw32_err", 64'(oerr32), 64'd1);
`endif
    send32(3'b100, 26'h037DDE0);
    check_val("iw32_hw1", 64'(bus32), 64'h0000_0000_BEEF_0000);
`ifdef IMMGEN_ERR_EN
    check_val("iw32_hw1_err", 64'(oerr32), 64'd0);
`endif
    send32(3'b010, 26'h2000000);
    check_val("b32_sext", 64'(bus32), 64'h0000_0000_FE00_0000);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge CLK);
    #1;
    check_val("final_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
